multiphase_square_gen: RTL and testbench

MULTIPHASE_SQUARE_GEN -- requirements
Module: multiphase_square_gen

---
 rtl/multiphase_square_gen_pkg.sv | 18 +
 rtl/sq_phase_ch.sv | 46 ++++
 rtl/multiphase_square_gen.sv | 159 +++++++++++++++
 tb/tb_multiphase_square_gen.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiphase_square_gen_pkg.sv
// Shared definitions for the multiphase square-wave generator: config address map and default phase offsets.
// Latency: none (constants and a pure function only).
// Backpressure: not applicable.
package multiphase_square_gen_pkg;

    // Configuration address map: half-period at 0, channel k offset at CH_BASE + k.
    localparam int ADDR_HALF = 0;
    localparam int CH_BASE   = 1;

    // Reset phase offset of channel k: channels spread evenly over one half-period,
    // so with two channels the second sits a quarter period (90 degrees) behind.
    function automatic int def_offset(input int k, input int def_half, input int num_ch);
        longint prod;
        prod = longint'(k) * longint'(def_half);
        return int'(prod / longint'(num_ch));
    endfunction

endpackage

// File: rtl/sq_phase_ch.sv
// One output channel: derives its phase from the shared master count and registers the square output.
// Latency: 1 clk_i cycle from cnt_i to sq_o.
// Backpressure: none; the output is forced low while en_i is low.
module sq_phase_ch
    import multiphase_square_gen_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W:0]   cnt_i,
    input  logic [CNT_W-1:0] half_i,
    input  logic [CNT_W-1:0] off_i,
    output logic             sq_o
);

    logic [CNT_W:0] period;
    logic [CNT_W:0] off_ext;
    logic [CNT_W:0] diff;
    logic [CNT_W:0] pc;
    logic           sq_d;
    logic           sq_q;

    // Phase = (cnt - off) mod P. Both operands are below P, so the wrapped
    // difference plus P lands back in range without needing an extra bit.
    always_comb begin
        period  = {half_i, 1'b0};
        off_ext = {1'b0, off_i};
        diff    = cnt_i - off_ext;
        pc      = (cnt_i >= off_ext) ? diff : (diff + period);
        sq_d    = en_i && (pc >= {1'b0, half_i});
    end

    // Output register: high for the second half of this channel's phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sq_q <= 1'b0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq_o = sq_q;

endmodule

// File: rtl/multiphase_square_gen.sv
// Multiphase square-wave generator: shared period counter, per-channel phase offsets, shadowed config.
// Latency: sq_out is 1 cycle behind the master count; period_tick is coincident with cnt = P-1.
// Backpressure: none; committed config waits for the next period boundary while enabled (cfg_pending).
module multiphase_square_gen
    import multiphase_square_gen_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 24,
    parameter int DEF_HALF = 250_000
) (
    input  logic                         clk_50M,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_CH+1)-1:0]  cfg_addr,
    input  logic [CNT_W-1:0]             cfg_data,
    input  logic                         cfg_commit,
    input  logic                         cfg_err_clr,
    output logic [NUM_CH-1:0]            sq_out,
    output logic                         period_tick,
    output logic                         cfg_pending,
    output logic                         cfg_err
);

    localparam int               AW         = $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] DEF_HALF_V = CNT_W'(DEF_HALF);
    localparam logic [CNT_W:0]   CNT_ONE    = {{CNT_W{1'b0}}, 1'b1};

    // Master counter and the active (in-use) configuration.
    logic [CNT_W:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] off_q [NUM_CH];
    logic [CNT_W-1:0] off_d [NUM_CH];

    // Shadow configuration written by software, copied to active on commit.
    logic [CNT_W-1:0] half_sh_q, half_sh_d;
    logic [CNT_W-1:0] off_sh_q [NUM_CH];
    logic [CNT_W-1:0] off_sh_d [NUM_CH];

    logic pending_q, pending_d;
    logic err_q, err_d;

    logic [CNT_W:0] period;
    logic           wrap;
    logic           apply;
    logic           wr_err;
    logic           clamp_err;

    // Period counter: counts 0..P-1 while enabled, parked at 0 otherwise.
    always_comb begin
        period = {half_q, 1'b0};
        wrap   = en && (cnt_q == (period - CNT_ONE));
        cnt_d  = cnt_q + CNT_ONE;
        if (!en || wrap) begin
            cnt_d = '0;
        end
    end

    // Shadow writes: a zero half-period is rejected and flagged; addresses past
    // the last channel fall through silently. The result feeds the commit path so
    // a write in the same cycle as a commit is part of the committed set.
    always_comb begin
        half_sh_d = half_sh_q;
        off_sh_d  = off_sh_q;
        wr_err    = 1'b0;
        if (cfg_we) begin
            if (cfg_addr == AW'(ADDR_HALF)) begin
                if (cfg_data == '0) begin
                    wr_err = 1'b1;
                end else begin
                    half_sh_d = cfg_data;
                end
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (cfg_addr == AW'(CH_BASE + k)) begin
                    off_sh_d[k] = cfg_data;
                end
            end
        end
    end

    // Commit handling: while running, changes land only on the wrap edge so every
    // channel sees a clean period boundary; while idle they land at the next edge.
    // Offsets that would not fit inside the new period collapse to 0 and flag an error.
    always_comb begin
        apply     = en ? (wrap && (pending_q || cfg_commit)) : (pending_q || cfg_commit);
        half_d    = half_q;
        off_d     = off_q;
        clamp_err = 1'b0;
        if (apply) begin
            half_d = half_sh_d;
            for (int k = 0; k < NUM_CH; k++) begin
                if ({1'b0, off_sh_d[k]} >= {half_sh_d, 1'b0}) begin
                    off_d[k]  = '0;
                    clamp_err = 1'b1;
                end else begin
                    off_d[k] = off_sh_d[k];
                end
            end
        end

        pending_d = pending_q;
        if (apply) begin
            pending_d = 1'b0;
        end else if (en && cfg_commit) begin
            pending_d = 1'b1;
        end

        err_d = err_q;
        if (wr_err || clamp_err) begin
            err_d = 1'b1;
        end else if (cfg_err_clr) begin
            err_d = 1'b0;
        end
    end

    // State registers; reset restores the default half-period and evenly spread offsets
    // and drops any commit that was still waiting for its boundary.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            half_q    <= DEF_HALF_V;
            half_sh_q <= DEF_HALF_V;
            for (int k = 0; k < NUM_CH; k++) begin
                off_q[k]    <= CNT_W'(def_offset(k, DEF_HALF, NUM_CH));
                off_sh_q[k] <= CNT_W'(def_offset(k, DEF_HALF, NUM_CH));
            end
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            half_sh_q <= half_sh_d;
            off_q     <= off_d;
            off_sh_q  <= off_sh_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sq_phase_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i  (clk_50M),
            .rst_i  (rst),
            .en_i   (en),
            .cnt_i  (cnt_q),
            .half_i (half_q),
            .off_i  (off_q[g]),
            .sq_o   (sq_out[g])
        );
    end

    assign period_tick = wrap;
    assign cfg_pending = pending_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_multiphase_square_gen.sv
// Directed bench for multiphase_square_gen with NUM_CH=4, CNT_W=8, DEF_HALF=8.
// Latency: samples on the falling edge, half a cycle after each active edge.
// Backpressure: not applicable.
module tb_multiphase_square_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_commit;
    logic       cfg_err_clr;
    logic [3:0] sq_out;
    logic       period_tick;
    logic       cfg_pending;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    logic [3:0] cap_sq [0:40];
    logic       cap_tk [0:40];
    logic       cap_pd [0:40];
    logic       cap_er [0:40];

    multiphase_square_gen #(
        .NUM_CH   (4),
        .CNT_W    (8),
        .DEF_HALF (8)
    ) dut (
        .clk_50M     (clk),
        .rst         (rst),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_commit  (cfg_commit),
        .cfg_err_clr (cfg_err_clr),
        .sq_out      (sq_out),
        .period_tick (period_tick),
        .cfg_pending (cfg_pending),
        .cfg_err     (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record n falling-edge samples; index 0 is the current sample. Config strobes drop after the first edge.
    task automatic capture(input int n);
        cap_sq[0] = sq_out; cap_tk[0] = period_tick; cap_pd[0] = cfg_pending; cap_er[0] = cfg_err;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            cfg_we = 1'b0; cfg_commit = 1'b0; cfg_err_clr = 1'b0;
            cap_sq[j] = sq_out; cap_tk[j] = period_tick; cap_pd[j] = cfg_pending; cap_er[j] = cfg_err;
        end
    endtask

    // Advance to the falling edge where period_tick is high (cnt = P-1), bounded.
    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < 64);
        checks++;
        if (period_tick !== 1'b1) begin errors++; $display("FAIL %s_tick_timeout got=%b exp=1", tag, period_tick); end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0; cfg_err_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sq_out !== 4'b0000) begin errors++; $display("FAIL rst_sq got=%b exp=0000", sq_out); end
        checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got=%b exp=0", period_tick); end
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL rst_pending got=%b exp=0", cfg_pending); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", cfg_err); end
    endtask

    // Release reset with en=1 and check the default 16-cycle waveform and 2/4/6 lags.
    task automatic test_default_wave(input string tag);
        int rise [4];
        int exp_rise [4] = '{9, 11, 13, 15};
        int ntick;
        int hi;
        rst = 1'b0;
        capture(40);
        for (int c = 0; c < 4; c++) begin
            rise[c] = -1;
            for (int j = 2; j <= 40; j++) begin
                if (rise[c] < 0 && cap_sq[j][c] && !cap_sq[j-1][c]) rise[c] = j;
            end
            checks++; if (rise[c] !== exp_rise[c]) begin errors++; $display("FAIL %s_rise_ch%0d got=%0d exp=%0d", tag, c, rise[c], exp_rise[c]); end
        end
        ntick = 0;
        for (int j = 1; j <= 40; j++) if (cap_tk[j]) ntick++;
        checks++; if (ntick !== 2) begin errors++; $display("FAIL %s_tick_count got=%0d exp=2", tag, ntick); end
        checks++; if (cap_tk[15] !== 1'b1) begin errors++; $display("FAIL %s_tick15 got=%b exp=1", tag, cap_tk[15]); end
        checks++; if (cap_tk[31] !== 1'b1) begin errors++; $display("FAIL %s_tick31 got=%b exp=1", tag, cap_tk[31]); end
        hi = 0;
        for (int j = 9; j <= 24; j++) if (cap_sq[j][0]) hi++;
        checks++; if (hi !== 8) begin errors++; $display("FAIL %s_ch0_high got=%0d exp=8", tag, hi); end
        checks++; if (cap_sq[1] !== 4'b1110) begin errors++; $display("FAIL %s_vec1 got=%b exp=1110", tag, cap_sq[1]); end
        checks++; if (cap_sq[9] !== 4'b0001) begin errors++; $display("FAIL %s_vec9 got=%b exp=0001", tag, cap_sq[9]); end
    endtask

    // Out-of-range address ignored; half=0 rejected (set wins over clear); commit keeps period 16.
    task automatic test_half_zero();
        int nt;
        cfg_we = 1'b1; cfg_addr = 3'd7; cfg_data = 8'd1;
        @(negedge clk);
        cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL hz_badaddr_err got=%b exp=0", cfg_err); end
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'd0; cfg_err_clr = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; cfg_err_clr = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL hz_err_set got=%b exp=1", cfg_err); end
        wait_tick("hz");
        @(negedge clk);
        cfg_commit = 1'b1;
        capture(31);
        checks++; if (cap_pd[1] !== 1'b1) begin errors++; $display("FAIL hz_pend1 got=%b exp=1", cap_pd[1]); end
        checks++; if (cap_pd[16] !== 1'b0) begin errors++; $display("FAIL hz_pend16 got=%b exp=0", cap_pd[16]); end
        checks++; if (cap_tk[15] !== 1'b1) begin errors++; $display("FAIL hz_tick15 got=%b exp=1", cap_tk[15]); end
        checks++; if (cap_tk[31] !== 1'b1) begin errors++; $display("FAIL hz_tick31 got=%b exp=1", cap_tk[31]); end
        nt = 0;
        for (int k = 16; k <= 30; k++) if (cap_tk[k]) nt++;
        checks++; if (nt !== 0) begin errors++; $display("FAIL hz_no_early_tick got=%0d exp=0", nt); end
        checks++; if (cap_er[31] !== 1'b1) begin errors++; $display("FAIL hz_err_sticky got=%b exp=1", cap_er[31]); end
        cfg_err_clr = 1'b1;
        @(negedge clk);
        cfg_err_clr = 1'b0;
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL hz_err_clr got=%b exp=0", cfg_err); end
    endtask

    // Commit half=5 at cnt=3: old 16-cycle period finishes, then 10-cycle periods.
    task automatic test_half_change();
        int hi;
        int nt;
        wait_tick("hc");
        repeat (4) @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'd5; cfg_commit = 1'b1;
        capture(32);
        checks++; if (cap_pd[1] !== 1'b1) begin errors++; $display("FAIL hc_pend1 got=%b exp=1", cap_pd[1]); end
        checks++; if (cap_pd[12] !== 1'b1) begin errors++; $display("FAIL hc_pend12 got=%b exp=1", cap_pd[12]); end
        checks++; if (cap_pd[13] !== 1'b0) begin errors++; $display("FAIL hc_pend13 got=%b exp=0", cap_pd[13]); end
        checks++; if (cap_tk[12] !== 1'b1) begin errors++; $display("FAIL hc_tick12 got=%b exp=1", cap_tk[12]); end
        nt = 0;
        for (int k = 13; k <= 21; k++) if (cap_tk[k]) nt++;
        checks++; if (nt !== 0) begin errors++; $display("FAIL hc_no_tick got=%0d exp=0", nt); end
        checks++; if (cap_tk[22] !== 1'b1) begin errors++; $display("FAIL hc_tick22 got=%b exp=1", cap_tk[22]); end
        checks++; if (cap_tk[32] !== 1'b1) begin errors++; $display("FAIL hc_tick32 got=%b exp=1", cap_tk[32]); end
        checks++; if (cap_sq[13][0] !== 1'b1) begin errors++; $display("FAIL hc_old_tail got=%b exp=1", cap_sq[13][0]); end
        checks++; if (cap_sq[18][0] !== 1'b0) begin errors++; $display("FAIL hc_ch0_18 got=%b exp=0", cap_sq[18][0]); end
        hi = 0;
        for (int k = 19; k <= 23; k++) if (cap_sq[k][0]) hi++;
        checks++; if (hi !== 5) begin errors++; $display("FAIL hc_ch0_high got=%0d exp=5", hi); end
        checks++; if (cap_sq[24][0] !== 1'b0) begin errors++; $display("FAIL hc_ch0_24 got=%b exp=0", cap_sq[24][0]); end
        checks++; if (cap_er[32] !== 1'b0) begin errors++; $display("FAIL hc_err got=%b exp=0", cap_er[32]); end
    endtask

    // Offset 12 on ch1 with half=5 does not fit: applied as 0 and flagged.
    task automatic test_offset_clamp();
        logic [1:0] exp2;
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 8'd12; cfg_commit = 1'b1;
        capture(30);
        checks++; if (cap_pd[9] !== 1'b1) begin errors++; $display("FAIL oc_pend9 got=%b exp=1", cap_pd[9]); end
        checks++; if (cap_pd[10] !== 1'b0) begin errors++; $display("FAIL oc_pend10 got=%b exp=0", cap_pd[10]); end
        checks++; if (cap_tk[9] !== 1'b1) begin errors++; $display("FAIL oc_tick9 got=%b exp=1", cap_tk[9]); end
        checks++; if (cap_er[9] !== 1'b0) begin errors++; $display("FAIL oc_err9 got=%b exp=0", cap_er[9]); end
        checks++; if (cap_er[10] !== 1'b1) begin errors++; $display("FAIL oc_err10 got=%b exp=1", cap_er[10]); end
        checks++; if (cap_sq[6][1:0] !== 2'b01) begin errors++; $display("FAIL oc_before got=%b exp=01", cap_sq[6][1:0]); end
        for (int k = 11; k <= 30; k++) begin
            exp2 = (((k - 1) % 10) >= 5) ? 2'b11 : 2'b00;
            checks++; if (cap_sq[k][1:0] !== exp2) begin errors++; $display("FAIL oc_aligned_%0d got=%b exp=%b", k, cap_sq[k][1:0], exp2); end
        end
        checks++; if (cap_er[30] !== 1'b1) begin errors++; $display("FAIL oc_err_sticky got=%b exp=1", cap_er[30]); end
        cfg_err_clr = 1'b1;
        @(negedge clk);
        cfg_err_clr = 1'b0;
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL oc_err_clr got=%b exp=0", cfg_err); end
    endtask

    // Drop en at cnt=5, commit half=8 while idle, re-enable: ch0 rises on the 9th edge.
    task automatic test_enable();
        wait_tick("en");
        repeat (6) @(negedge clk);
        checks++; if (sq_out !== 4'b1000) begin errors++; $display("FAIL en_before got=%b exp=1000", sq_out); end
        en = 1'b0;
        @(negedge clk);
        checks++; if (sq_out !== 4'b0000) begin errors++; $display("FAIL en_off_sq got=%b exp=0000", sq_out); end
        checks++; if (period_tick !== 1'b0) begin errors++; $display("FAIL en_off_tick got=%b exp=0", period_tick); end
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'd8; cfg_commit = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; cfg_commit = 1'b0;
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL en_idle_pend got=%b exp=0", cfg_pending); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL en_idle_err got=%b exp=0", cfg_err); end
        repeat (2) @(negedge clk);
        checks++; if (sq_out !== 4'b0000) begin errors++; $display("FAIL en_hold_sq got=%b exp=0000", sq_out); end
        en = 1'b1;
        capture(16);
        checks++; if (cap_sq[8][0] !== 1'b0) begin errors++; $display("FAIL en_ch0_8 got=%b exp=0", cap_sq[8][0]); end
        checks++; if (cap_sq[9][0] !== 1'b1) begin errors++; $display("FAIL en_ch0_9 got=%b exp=1", cap_sq[9][0]); end
        checks++; if (cap_tk[14] !== 1'b0) begin errors++; $display("FAIL en_tick14 got=%b exp=0", cap_tk[14]); end
        checks++; if (cap_tk[15] !== 1'b1) begin errors++; $display("FAIL en_tick15 got=%b exp=1", cap_tk[15]); end
    endtask

    // Reset while a half=3 commit is pending: outputs drop at once and defaults return.
    task automatic test_reset_pending();
        int rise1;
        int npd;
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'd3; cfg_commit = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; cfg_commit = 1'b0;
        checks++; if (cfg_pending !== 1'b1) begin errors++; $display("FAIL rp_pend got=%b exp=1", cfg_pending); end
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'd0;
        @(negedge clk);
        cfg_we = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rp_err_pre got=%b exp=1", cfg_err); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (sq_out !== 4'b0000) begin errors++; $display("FAIL rp_sq got=%b exp=0000", sq_out); end
        checks++; if (cfg_pending !== 1'b0) begin errors++; $display("FAIL rp_pend_rst got=%b exp=0", cfg_pending); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rp_err_rst got=%b exp=0", cfg_err); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        capture(32);
        checks++; if (cap_tk[5] !== 1'b0) begin errors++; $display("FAIL rp_tick5 got=%b exp=0", cap_tk[5]); end
        checks++; if (cap_tk[15] !== 1'b1) begin errors++; $display("FAIL rp_tick15 got=%b exp=1", cap_tk[15]); end
        checks++; if (cap_tk[31] !== 1'b1) begin errors++; $display("FAIL rp_tick31 got=%b exp=1", cap_tk[31]); end
        checks++; if (cap_sq[1] !== 4'b1110) begin errors++; $display("FAIL rp_vec1 got=%b exp=1110", cap_sq[1]); end
        rise1 = -1;
        for (int j = 2; j <= 32; j++) if (rise1 < 0 && cap_sq[j][1] && !cap_sq[j-1][1]) rise1 = j;
        checks++; if (rise1 !== 11) begin errors++; $display("FAIL rp_rise_ch1 got=%0d exp=11", rise1); end
        npd = 0;
        for (int j = 1; j <= 32; j++) if (cap_pd[j]) npd++;
        checks++; if (npd !== 0) begin errors++; $display("FAIL rp_no_pend got=%0d exp=0", npd); end
    endtask

    initial begin
        test_reset();
        test_default_wave("dflt");
        test_half_zero();
        test_half_change();
        test_offset_clamp();
        test_enable();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
